// File: rtl/jtag_scan_pkg.sv
// Shared types and TMS patterns for the JTAG scan master.
// Patterns are stored LSB-first: bit i is the TMS value of the i-th period.
package jtag_scan_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_SEL_IR = 3'd2,
    ST_PRE    = 3'd3,
    ST_SHIFT  = 3'd4,
    ST_POST   = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    OP_DR    = 2'b00,
    OP_IR    = 2'b01,
    OP_RESET = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  localparam logic [7:0] PRE_TMS   = 8'b0000_0001;  // 1,0,0
  localparam logic [7:0] POST_TMS  = 8'b0000_0001;  // 1,0
  localparam logic [7:0] RESET_TMS = 8'b0001_1111;  // 1,1,1,1,1,0

  localparam logic [6:0] PRE_LAST   = 7'd2;
  localparam logic [6:0] POST_LAST  = 7'd1;
  localparam logic [6:0] RESET_LAST = 7'd5;

  function automatic logic pattern_bit(input logic [7:0] pat, input logic [2:0] idx);
    return pat[idx];
  endfunction

  function automatic logic [6:0] decode_len(input logic [5:0] len);
    if (len == 6'd0) begin
      return 7'd64;
    end else begin
      return {1'b0, len};
    end
  endfunction

endpackage

// File: rtl/jtag_scan_master_if.sv
// Command/response channel of the JTAG scan master.
// The master modport belongs to the command issuer, slave to the scan engine.
interface jtag_scan_master_if #(parameter int MAXLEN = 64);
  import jtag_scan_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [5:0]        cmd_len;
  logic [MAXLEN-1:0] cmd_data;
  logic              rsp_valid;
  logic [MAXLEN-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/jtag_shift_reg.sv
// Scan data path: TDI bits leave from bit 0 of a right-shifting register,
// TDO bits are written into the capture image at the current bit index.
module jtag_shift_reg
  import jtag_scan_pkg::*;
#(
  parameter int MAXLEN = 64
) (
  input  logic                      CK,
  input  logic                      RST,
  input  logic                      load,
  input  logic [MAXLEN-1:0]         load_data,
  input  logic                      shift,
  output logic                      sout,
  input  logic                      capture,
  input  logic [$clog2(MAXLEN)-1:0] idx,
  input  logic                      sin,
  output logic [MAXLEN-1:0]         cap_data
);

  logic [MAXLEN-1:0] out_bits;

  // Load clears the capture image so bits never shifted read back as zero.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      out_bits <= {MAXLEN{1'b0}};
      cap_data <= {MAXLEN{1'b0}};
    end else if (load) begin
      out_bits <= load_data;
      cap_data <= {MAXLEN{1'b0}};
    end else begin
      if (shift) begin
        out_bits <= {1'b0, out_bits[MAXLEN-1:1]};
      end else begin
        out_bits <= out_bits;
      end
      if (capture) begin
        cap_data[idx] <= sin;
      end else begin
        cap_data <= cap_data;
      end
    end
  end

  assign sout = out_bits[0];

endmodule

// File: rtl/jtag_scan_master.sv
// JTAG scan master: turns DR/IR/TAP-reset commands into TCK/TMS/TDI waveforms,
// two CK cycles per TCK period (low phase, then high phase).
module jtag_scan_master
  import jtag_scan_pkg::*;
#(
  parameter int MAXLEN = 64
) (
  input  logic                    CK,
  input  logic                    RST,
  jtag_scan_master_if.slave       bus,
  output logic                    TCK,
  output logic                    TMS,
  output logic                    TDI,
  input  logic                    TDO
);

  localparam int IW = $clog2(MAXLEN);

  state_e            state;
  logic              phase_high;
  logic [6:0]        cnt;
  logic [6:0]        len;
  logic              respond;
  logic              ready;
  logic              rsp_pulse;
  logic [MAXLEN-1:0] rsp_hold;

  logic              accept;
  logic [6:0]        cnt_nxt;
  logic [6:0]        last_bit;
  logic              shift_en;
  logic              cap_en;
  logic              sout;
  logic [MAXLEN-1:0] cap_data;

  // Handshake and data-path strobes derived from the current state and phase.
  always_comb begin
    accept   = 1'b0;
    shift_en = 1'b0;
    cap_en   = 1'b0;
    cnt_nxt  = cnt + 7'd1;
    last_bit = len - 7'd1;
    if ((state == ST_IDLE) && bus.cmd_valid && ready) begin
      accept = 1'b1;
    end else begin
      accept = 1'b0;
    end
    if ((state == ST_PRE) && phase_high && (cnt == PRE_LAST)) begin
      shift_en = 1'b1;
    end else if ((state == ST_SHIFT) && phase_high && (cnt != last_bit)) begin
      shift_en = 1'b1;
    end else begin
      shift_en = 1'b0;
    end
    if ((state == ST_SHIFT) && !phase_high) begin
      cap_en = 1'b1;
    end else begin
      cap_en = 1'b0;
    end
  end

  // Sequencer: TMS/TDI change only on the edge that opens a low phase.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state      <= ST_INIT;
      phase_high <= 1'b0;
      cnt        <= 7'd0;
      len        <= 7'd0;
      respond    <= 1'b0;
      ready      <= 1'b0;
      rsp_pulse  <= 1'b0;
      rsp_hold   <= {MAXLEN{1'b0}};
      TCK        <= 1'b0;
      TMS        <= 1'b1;
      TDI        <= 1'b0;
    end else begin
      rsp_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ready      <= 1'b0;
            respond    <= 1'b1;
            len        <= decode_len(bus.cmd_len);
            cnt        <= 7'd0;
            phase_high <= 1'b0;
            TCK        <= 1'b0;
            TDI        <= 1'b0;
            case (op_e'(bus.cmd_op))
              OP_DR: begin
                state <= ST_PRE;
                TMS   <= pattern_bit(PRE_TMS, 3'd0);
              end
              OP_IR: begin
                state <= ST_SEL_IR;
                TMS   <= 1'b1;
              end
              default: begin
                state <= ST_INIT;
                TMS   <= pattern_bit(RESET_TMS, 3'd0);
              end
            endcase
          end else begin
            ready <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
        default: begin
          if (!phase_high) begin
            TCK        <= 1'b1;
            phase_high <= 1'b1;
          end else begin
            TCK        <= 1'b0;
            phase_high <= 1'b0;
            case (state)
              ST_INIT: begin
                if (cnt == RESET_LAST) begin
                  cnt <= 7'd0;
                  if (respond) begin
                    state     <= ST_DONE;
                    rsp_pulse <= 1'b1;
                    rsp_hold  <= cap_data;
                  end else begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                  end
                end else begin
                  cnt <= cnt_nxt;
                  TMS <= pattern_bit(RESET_TMS, cnt_nxt[2:0]);
                end
              end
              ST_SEL_IR: begin
                state <= ST_PRE;
                cnt   <= 7'd0;
                TMS   <= pattern_bit(PRE_TMS, 3'd0);
              end
              ST_PRE: begin
                if (cnt == PRE_LAST) begin
                  state <= ST_SHIFT;
                  cnt   <= 7'd0;
                  TMS   <= (len == 7'd1);
                  TDI   <= sout;
                end else begin
                  cnt <= cnt_nxt;
                  TMS <= pattern_bit(PRE_TMS, cnt_nxt[2:0]);
                end
              end
              ST_SHIFT: begin
                if (cnt == last_bit) begin
                  state <= ST_POST;
                  cnt   <= 7'd0;
                  TMS   <= pattern_bit(POST_TMS, 3'd0);
                  TDI   <= 1'b0;
                end else begin
                  cnt <= cnt_nxt;
                  TMS <= (cnt_nxt == last_bit);
                  TDI <= sout;
                end
              end
              ST_POST: begin
                if (cnt == POST_LAST) begin
                  state     <= ST_DONE;
                  cnt       <= 7'd0;
                  rsp_pulse <= 1'b1;
                  rsp_hold  <= cap_data;
                end else begin
                  cnt <= cnt_nxt;
                  TMS <= pattern_bit(POST_TMS, cnt_nxt[2:0]);
                end
              end
              default: begin
                state <= ST_INIT;
                cnt   <= 7'd0;
                TMS   <= 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

  jtag_shift_reg #(.MAXLEN(MAXLEN)) u_shift (
    .CK        (CK),
    .RST       (RST),
    .load      (accept),
    .load_data (bus.cmd_data),
    .shift     (shift_en),
    .sout      (sout),
    .capture   (cap_en),
    .idx       (cnt[IW-1:0]),
    .sin       (TDO),
    .cap_data  (cap_data)
  );

  assign bus.cmd_ready = ready;
  assign bus.rsp_valid = rsp_pulse;
  assign bus.rsp_data  = rsp_hold;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Directed bench for jtag_scan_master with a behavioural TAP and a response scoreboard.
module tb_jtag_scan_master;
  import jtag_scan_pkg::*;

  localparam logic [63:0] DR_CAP = 64'hC3A5_9617_E248_D03C;

  typedef enum logic [3:0] {
    TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
    SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR
  } tap_e;

  logic CK  = 1'b0;
  logic RST = 1'b1;
  logic TCK, TMS, TDI;
  logic TDO = 1'b0;

  jtag_scan_master_if #(.MAXLEN(64)) bus();

  jtag_scan_master #(.MAXLEN(64)) dut (
    .CK  (CK),
    .RST (RST),
    .bus (bus.slave),
    .TCK (TCK),
    .TMS (TMS),
    .TDI (TDI),
    .TDO (TDO)
  );

  always #5 CK = ~CK;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rsp_cnt  = 0;
  int obs_n    = 0;
  int acc_cyc  = 0;
  int rsp_cyc  = 0;
  logic [127:0] obs_tms = 128'd0;
  logic [127:0] obs_tdi = 128'd0;
  logic [63:0]  exp_q[$];

  tap_e       tap    = TLR;
  logic [63:0] dr    = 64'd0;
  logic [3:0]  ir    = 4'd0;
  logic [3:0]  ir_upd = 4'd0;

  always @(posedge CK) cyc <= cyc + 1;

  always @(negedge CK) if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;

  always @(posedge TCK) begin
    if (obs_n < 128) begin
      obs_tms[obs_n] <= TMS;
      obs_tdi[obs_n] <= TDI;
    end
    obs_n <= obs_n + 1;
  end

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      TLR:     return m ? TLR  : RTI;
      RTI:     return m ? SDR  : RTI;
      SDR:     return m ? SIR  : CDR;
      CDR:     return m ? E1DR : SHDR;
      SHDR:    return m ? E1DR : SHDR;
      E1DR:    return m ? UDR  : PDR;
      PDR:     return m ? E2DR : PDR;
      E2DR:    return m ? UDR  : SHDR;
      UDR:     return m ? SDR  : RTI;
      SIR:     return m ? TLR  : CIR;
      CIR:     return m ? E1IR : SHIR;
      SHIR:    return m ? E1IR : SHIR;
      E1IR:    return m ? UIR  : PIR;
      PIR:     return m ? E2IR : PIR;
      E2IR:    return m ? UIR  : SHIR;
      UIR:     return m ? SDR  : RTI;
      default: return TLR;
    endcase
  endfunction

  always @(posedge TCK) begin
    case (tap)
      CDR:     dr <= DR_CAP;
      SHDR:    dr <= {TDI, dr[63:1]};
      CIR:     ir <= 4'b0001;
      SHIR:    ir <= {TDI, ir[3:1]};
      UIR:     ir_upd <= ir;
      default: ;
    endcase
    tap <= tap_next(tap, TMS);
  end

  always @(negedge TCK) TDO <= (tap == SHDR) ? dr[0] : ((tap == SHIR) ? ir[0] : 1'b0);

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected per-period TMS/TDI, derived directly from the command definition.
  function automatic void exp_pat(input logic [1:0] op, input logic [5:0] len, input logic [63:0] data,
                                  output logic [127:0] tms, output logic [127:0] tdi, output int np);
    int n;
    n   = (len == 6'd0) ? 64 : int'(len);
    tms = 128'd0;
    tdi = 128'd0;
    np  = 0;
    if (op[1]) begin
      for (int i = 0; i < 6; i++) begin
        tms[np] = (i < 5);
        np++;
      end
    end else begin
      if (op == 2'b01) begin
        tms[np] = 1'b1; np++;
      end
      tms[np] = 1'b1; np++;
      tms[np] = 1'b0; np++;
      tms[np] = 1'b0; np++;
      for (int k = 0; k < n; k++) begin
        tms[np] = (k == n - 1);
        tdi[np] = data[k];
        np++;
      end
      tms[np] = 1'b1; np++;
      tms[np] = 1'b0; np++;
    end
  endfunction

  task automatic reset_check(input string tag);
    check({tag, "_tck"},   128'(TCK),           128'd0);
    check({tag, "_tms"},   128'(TMS),           128'd1);
    check({tag, "_tdi"},   128'(TDI),           128'd0);
    check({tag, "_ready"}, 128'(bus.cmd_ready), 128'd0);
    check({tag, "_rspv"},  128'(bus.rsp_valid), 128'd0);
    check({tag, "_rspd"},  128'(bus.rsp_data),  128'd0);
  endtask

  task automatic init_check(input string tag);
    int r0;
    @(negedge CK);
    r0 = rsp_cnt;
    RST = 1'b0;
    obs_n = 0; obs_tms = 128'd0; obs_tdi = 128'd0;
    repeat (11) @(posedge CK);
    #1;
    check({tag, "_ready_ck11"}, 128'(bus.cmd_ready), 128'd0);
    @(posedge CK);
    #1;
    check({tag, "_ready_ck12"}, 128'(bus.cmd_ready), 128'd1);
    check({tag, "_periods"},    128'(obs_n),         128'd6);
    check({tag, "_tms"},        obs_tms,             128'h1F);
    check({tag, "_tdi"},        obs_tdi,             128'd0);
    check({tag, "_tap_rti"},    128'(tap),           128'(RTI));
    check({tag, "_no_rsp"},     128'(rsp_cnt),       128'(r0));
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] len, input logic [63:0] data,
                       input logic [63:0] exp_rsp, input bit hold);
    int w;
    w = 0;
    @(negedge CK);
    bus.cmd_op = op; bus.cmd_len = len; bus.cmd_data = data; bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && w < 50) begin
      @(negedge CK);
      w++;
    end
    check("accept_wait", 128'(w < 50), 128'd1);
    exp_q.push_back(exp_rsp);
    @(negedge CK);
    acc_cyc = cyc;
    obs_n = 0; obs_tms = 128'd0; obs_tdi = 128'd0;
    if (!hold) begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op = ~op; bus.cmd_len = ~len; bus.cmd_data = ~data;
    end
  endtask

  task automatic await(input string tag, input logic [1:0] op, input logic [5:0] len,
                       input logic [63:0] data, input int exp_lat);
    logic [127:0] et, ed;
    logic [63:0]  er;
    int np, w;
    exp_pat(op, len, data, et, ed, np);
    w = 0;
    @(negedge CK);
    while (!bus.rsp_valid && w < 400) begin
      @(negedge CK);
      w++;
    end
    rsp_cyc = cyc;
    check({tag, "_latency"}, 128'(rsp_cyc - acc_cyc), 128'(exp_lat));
    if (exp_q.size() > 0) er = exp_q.pop_front();
    else er = {64{1'bx}};
    check({tag, "_rsp_data"}, 128'(bus.rsp_data), 128'(er));
    check({tag, "_periods"},  128'(obs_n),        128'(np));
    check({tag, "_tms"},      obs_tms,            et);
    check({tag, "_tdi"},      obs_tdi,            ed);
    @(negedge CK);
    check({tag, "_rspv_one"},  128'(bus.rsp_valid), 128'd0);
    check({tag, "_rsp_hold"},  128'(bus.rsp_data),  128'(er));
    check({tag, "_idle_rdy"},  128'(bus.cmd_ready), 128'd1);
    check({tag, "_idle_tck"},  128'(TCK),           128'd0);
  endtask

  initial begin
    int w;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_len   = 6'd0;
    bus.cmd_data  = 64'd0;
    repeat (3) @(negedge CK);
    reset_check("rst");
    init_check("init");

    issue(2'b00, 6'd8, 64'hA5, 64'h3C, 1'b0);
    await("dr8", 2'b00, 6'd8, 64'hA5, 26);

    issue(2'b01, 6'd4, 64'h2, 64'h1, 1'b0);
    await("ir4", 2'b01, 6'd4, 64'h2, 20);
    check("ir4_update", 128'(ir_upd), 128'h2);

    issue(2'b10, 6'd0, 64'hFFFF, 64'h0, 1'b0);
    await("tapreset", 2'b10, 6'd0, 64'hFFFF, 12);
    check("tapreset_rti", 128'(tap), 128'(RTI));

    issue(2'b11, 6'd9, 64'h1234, 64'h0, 1'b0);
    await("rsvd", 2'b11, 6'd9, 64'h1234, 12);

    issue(2'b00, 6'd0, {64{1'b1}}, DR_CAP, 1'b0);
    await("len64", 2'b00, 6'd0, {64{1'b1}}, 138);

    issue(2'b00, 6'd8, 64'h5A, 64'h3C, 1'b1);
    bus.cmd_op = 2'b00; bus.cmd_len = 6'd5; bus.cmd_data = 64'h15;
    await("b2b_a", 2'b00, 6'd8, 64'h5A, 26);
    exp_q.push_back(DR_CAP & 64'h1F);
    @(negedge CK);
    check("b2b_taken", 128'(bus.cmd_ready), 128'd0);
    check("b2b_gap",   128'(cyc - rsp_cyc), 128'd2);
    check("b2b_tck",   128'(TCK),           128'd0);
    acc_cyc = cyc;
    obs_n = 0; obs_tms = 128'd0; obs_tdi = 128'd0;
    bus.cmd_valid = 1'b0;
    await("b2b_b", 2'b00, 6'd5, 64'h15, 20);

    issue(2'b00, 6'd16, 64'hBEEF, 64'h0, 1'b0);
    w = 0;
    while (obs_n < 7 && w < 100) begin
      @(negedge CK);
      w++;
    end
    check("abort_at_bit3", 128'(obs_n), 128'd7);
    RST = 1'b1;
    #1;
    reset_check("abort");
    exp_q.delete();
    repeat (2) @(negedge CK);
    init_check("reinit");
    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
